dht11_rx_bcd: RTL and testbench

- Single-wire DHT11 humidity/temperature receiver.
- Triggers a measurement, decodes the 40-bit frame and verifies the checksum.
- Converts the four data bytes to BCD digits in XX.XX order and holds them for the downstream 7-segment display controller.
- Sits between the board's DHT11 pin and the FND controller; runs in the system clock domain.

---
 rtl/dht11_rx_bcd_pkg.sv | 29 ++
 rtl/dht11_rx_bcd_byte2bcd.sv | 12 +
 rtl/dht11_rx_bcd.sv | 175 +++++++++++++++++
 tb/tb_dht11_rx_bcd.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_rx_bcd_pkg.sv
// Shared definitions for the DHT11 receiver and the display side that consumes its digits.
`timescale 1ns/1ps
package dht11_rx_bcd_pkg;

    localparam int FRAME_BITS = 40;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_WAIT_RESP = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7,
        ST_CONVERT   = 4'd8
    } state_t;

    typedef enum logic {
        MODE_HUMIDITY    = 1'b0,
        MODE_TEMPERATURE = 1'b1
    } mode_t;

    // States in which the sensor owns the line and the dwell timeout applies.
    function automatic logic is_wait_state(input state_t s);
        return s inside {ST_WAIT_RESP, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH};
    endfunction

endpackage

// File: rtl/dht11_rx_bcd_byte2bcd.sv
// Combinational 0..99 to two BCD digits; inputs above 99 are rejected upstream.
`timescale 1ns/1ps
module byte2bcd (
    input  logic [7:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    assign o_tens = 4'(i_bin / 8'd10);
    assign o_ones = 4'(i_bin % 8'd10);

endmodule

// File: rtl/dht11_rx_bcd.sv
// DHT11 single-wire receiver: start pulse, 40-bit frame capture, checksum/range check,
// and BCD digits (XX.XX) held for the 7-segment controller.
`timescale 1ns/1ps
module dht11_rx_bcd
    import dht11_rx_bcd_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int START_LOW_US   = 18000,
    parameter int BIT1_THRESH_US = 40,
    parameter int TIMEOUT_US     = 200,
    parameter int POLL_MS        = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    inout  wire        io_dht,
    output logic [3:0] o_hum1000,
    output logic [3:0] o_hum100,
    output logic [3:0] o_hum10,
    output logic [3:0] o_hum1,
    output logic [3:0] o_temp1000,
    output logic [3:0] o_temp100,
    output logic [3:0] o_temp10,
    output logic [3:0] o_temp1,
    output logic       o_busy,
    output logic       o_valid,
    output logic       o_err
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int US_MAX   = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int US_W     = $clog2(US_MAX + 2);
    localparam int POLL_US  = POLL_MS * 1000;
    localparam int POLL_W   = (POLL_US > 1) ? $clog2(POLL_US) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [1:0]          r_sync;
    logic                r_line_d;
    logic [US_W-1:0]     r_us_cnt;
    logic [POLL_W-1:0]   r_poll_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [5:0]          r_bit_idx;
    logic                r_err;
    logic [7:0][3:0]     r_dig;

    logic       w_tick, w_rise, w_fall, w_poll, w_timeout, w_bit, w_last_bit;
    logic       w_frame_ok, w_oe;
    logic [7:0] w_sum;
    logic [7:0] w_byte [5];
    logic [3:0] w_tens [4];
    logic [3:0] w_ones [4];

    assign io_dht = w_oe ? 1'b0 : 1'bz;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    // Edges come from the synchronized level, so both edges see the same delay.
    assign w_rise = r_sync[1] & ~r_line_d;
    assign w_fall = ~r_sync[1] & r_line_d;

    assign w_poll     = (POLL_MS != 0) && (r_state == ST_IDLE) && w_tick &&
                        (r_poll_cnt == POLL_W'(POLL_US - 1));
    assign w_timeout  = is_wait_state(r_state) && (r_us_cnt > US_W'(TIMEOUT_US));
    assign w_bit      = (r_us_cnt >= US_W'(BIT1_THRESH_US));
    assign w_last_bit = (r_bit_idx == 6'(FRAME_BITS - 1));

    for (genvar g = 0; g < 5; g++) begin : g_byte
        assign w_byte[g] = r_shift[FRAME_BITS-1-8*g -: 8];
    end

    for (genvar g = 0; g < 4; g++) begin : g_bcd
        byte2bcd u_byte2bcd (
            .i_bin  (w_byte[g]),
            .o_tens (w_tens[g]),
            .o_ones (w_ones[g])
        );
    end

    assign w_sum      = w_byte[0] + w_byte[1] + w_byte[2] + w_byte[3];
    assign w_frame_ok = (w_sum == w_byte[4]) && (w_byte[0] <= 8'd99) && (w_byte[1] <= 8'd99) &&
                        (w_byte[2] <= 8'd99) && (w_byte[3] <= 8'd99);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (i_start || w_poll) w_next = ST_START_LOW;
                ST_START_LOW: if (r_us_cnt >= US_W'(START_LOW_US)) w_next = ST_WAIT_RESP;
                ST_WAIT_RESP: if (w_fall) w_next = ST_RESP_LOW;
                ST_RESP_LOW:  if (w_rise) w_next = ST_RESP_HIGH;
                ST_RESP_HIGH: if (w_fall) w_next = ST_BIT_LOW;
                ST_BIT_LOW:   if (w_rise) w_next = ST_BIT_HIGH;
                ST_BIT_HIGH:  if (w_fall) w_next = w_last_bit ? ST_CHECK : ST_BIT_LOW;
                ST_CHECK:     w_next = w_frame_ok ? ST_CONVERT : ST_IDLE;
                ST_CONVERT:   w_next = ST_IDLE;
                default:      w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy  = (r_state != ST_IDLE);
        o_valid = (r_state == ST_CONVERT);
        w_oe    = (r_state == ST_START_LOW);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tick_cnt <= '0;
            r_sync     <= 2'b11;
            r_line_d   <= 1'b1;
            r_us_cnt   <= '0;
            r_poll_cnt <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_err      <= 1'b0;
            r_dig      <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            r_sync     <= {r_sync[0], io_dht};
            r_line_d   <= r_sync[1];

            // A tick in the entry cycle is counted, so a width of N us reads exactly N.
            if (w_next != r_state)
                r_us_cnt <= w_tick ? US_W'(1) : '0;
            else if (w_tick && (r_us_cnt != '1))
                r_us_cnt <= r_us_cnt + US_W'(1);

            if ((r_state != ST_IDLE) || w_poll)
                r_poll_cnt <= '0;
            else if (w_tick)
                r_poll_cnt <= r_poll_cnt + POLL_W'(1);

            if (r_state == ST_RESP_HIGH)
                r_bit_idx <= '0;
            if ((r_state == ST_BIT_HIGH) && w_fall) begin
                r_shift   <= {r_shift[FRAME_BITS-2:0], w_bit};
                r_bit_idx <= r_bit_idx + 6'd1;
            end

            if (w_timeout)
                r_err <= 1'b1;
            // Digits load on entry to CONVERT so they are already valid while o_valid is high.
            if (r_state == ST_CHECK) begin
                if (w_frame_ok) begin
                    r_err <= 1'b0;
                    r_dig <= {w_tens[0], w_ones[0], w_tens[1], w_ones[1],
                              w_tens[2], w_ones[2], w_tens[3], w_ones[3]};
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_hum1000  = r_dig[7];
    assign o_hum100   = r_dig[6];
    assign o_hum10    = r_dig[5];
    assign o_hum1     = r_dig[4];
    assign o_temp1000 = r_dig[3];
    assign o_temp100  = r_dig[2];
    assign o_temp10   = r_dig[1];
    assign o_temp1    = r_dig[0];
    assign o_err      = r_err;

endmodule

// File: tb/tb_dht11_rx_bcd.sv
// Directed bench for dht11_rx_bcd: sensor model on two lines, one manual and one auto-polled instance.
`timescale 1ns/1ps
module tb_dht11_rx_bcd;

    localparam int US = 1000;

    logic clk;
    logic rst_a, rst_b, start_a, start_b;
    logic sa_low, sb_low;
    wire  dht_a, dht_b;
    wire  [31:0] a_dig, b_dig;
    wire  a_busy, a_valid, a_err, b_busy, b_valid, b_err;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          a_vcnt = 0;
    int          b_vcnt = 0;
    int unsigned b_valid_cyc = 0;
    int unsigned t_start [2];
    int unsigned t_rel_b;
    bit          poll_done = 0;

    assign dht_a = sa_low ? 1'b0 : 1'bz;
    assign dht_b = sb_low ? 1'b0 : 1'bz;
    pullup (dht_a);
    pullup (dht_b);

    // clock / reset
    initial clk = 1'b0;
    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dht11_rx_bcd #(.CLK_FREQ_HZ(10_000_000), .START_LOW_US(100), .POLL_MS(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .io_dht(dht_a),
        .o_hum1000(a_dig[31:28]), .o_hum100(a_dig[27:24]), .o_hum10(a_dig[23:20]), .o_hum1(a_dig[19:16]),
        .o_temp1000(a_dig[15:12]), .o_temp100(a_dig[11:8]), .o_temp10(a_dig[7:4]), .o_temp1(a_dig[3:0]),
        .o_busy(a_busy), .o_valid(a_valid), .o_err(a_err)
    );

    dht11_rx_bcd #(.CLK_FREQ_HZ(10_000_000), .START_LOW_US(100), .POLL_MS(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .io_dht(dht_b),
        .o_hum1000(b_dig[31:28]), .o_hum100(b_dig[27:24]), .o_hum10(b_dig[23:20]), .o_hum1(b_dig[19:16]),
        .o_temp1000(b_dig[15:12]), .o_temp100(b_dig[11:8]), .o_temp10(b_dig[7:4]), .o_temp1(b_dig[3:0]),
        .o_busy(b_busy), .o_valid(b_valid), .o_err(b_err)
    );

    // scoreboard counters for valid pulses
    always @(negedge clk) begin
        if (a_valid) a_vcnt <= a_vcnt + 1;
        if (b_valid) begin
            b_vcnt      <= b_vcnt + 1;
            b_valid_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic line(input int idx);
        return (idx == 0) ? dht_a : dht_b;
    endfunction

    task automatic drive(input int idx, input logic v);
        if (idx == 0) sa_low = v;
        else          sb_low = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_us(input int n);
        #(n * US);
        wait_cyc(1);
    endtask

    task automatic pulse_start;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    function automatic int bit_us(input logic b, input int i, input bit mix);
        if (mix) return b ? (((i % 2) != 0) ? 70 : 40) : (((i % 2) != 0) ? 39 : 28);
        return b ? 42 : 10;
    endfunction

    // Sensor model: answer the host start pulse and send a frame; stop_at >= 0 abandons
    // the frame with the line released in the high phase of that bit.
    task automatic sensor_frame(input int idx, input logic [39:0] frame, input int stop_at,
                                input bit mix, input int limit, output bit ok);
        int k;
        ok = 1'b0;
        k = 0;
        while (line(idx) !== 1'b0 && k < limit) begin @(posedge clk); k++; end
        if (k >= limit) return;
        t_start[idx] = cyc;
        k = 0;
        while (line(idx) !== 1'b1 && k < limit) begin @(posedge clk); k++; end
        if (k >= limit) return;
        ok = 1'b1;
        #30;
        #(10 * US); drive(idx, 1'b1);
        #(20 * US); drive(idx, 1'b0);
        #(20 * US);
        for (int i = 0; i < 40; i++) begin
            drive(idx, 1'b1); #(3 * US); drive(idx, 1'b0);
            if (i == stop_at) return;
            #(bit_us(frame[39-i], i, mix) * US);
        end
        drive(idx, 1'b1); #(3 * US); drive(idx, 1'b0);
    endtask

    // auto-poll instance: two frames, each triggered 1 ms after IDLE entry
    task automatic poll_seq;
        bit ok;
        int v0;
        sensor_frame(1, 40'h2D_00_17_07_4B, -1, 1'b0, 12000, ok);
        chk("b_start1_seen", 32'(ok), 32'd1);
        chk("b_gap_reset", 32'((t_start[1] - t_rel_b >= 9985) && (t_start[1] - t_rel_b <= 10030)), 32'd1);
        wait_cyc(20);
        chk("b_vcnt1", 32'(b_vcnt), 32'd1);
        chk("b_digits1", b_dig, 32'h4500_2307);
        v0 = b_vcnt;
        // second frame has humidity 100 with a correct checksum: range failure
        sensor_frame(1, 40'h64_00_10_00_74, -1, 1'b0, 12000, ok);
        chk("b_start2_seen", 32'(ok), 32'd1);
        chk("b_gap_idle", 32'((t_start[1] - b_valid_cyc >= 9985) && (t_start[1] - b_valid_cyc <= 10030)), 32'd1);
        wait_cyc(20);
        chk("b_range_err", {b_busy, b_err}, 32'b01);
        chk("b_range_novalid", 32'(b_vcnt), 32'(v0));
        chk("b_range_hold", b_dig, 32'h4500_2307);
        poll_done = 1'b1;
    endtask

    initial begin
        bit ok;
        int v0;
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        sa_low = 1'b0; sb_low = 1'b0;
        wait_cyc(5);
        chk("rst_digits", a_dig, 32'h0);
        chk("rst_flags", {a_busy, a_valid, a_err}, 32'b000);
        chk("rst_line", 32'(dht_a), 32'd1);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        t_rel_b = cyc;
        fork
            poll_seq();
        join_none

        // good frame
        v0 = a_vcnt;
        pulse_start();
        wait_cyc(5);
        chk("f1_busy_drive", {a_busy, dht_a}, 32'b10);
        sensor_frame(0, 40'h2D_00_17_07_4B, -1, 1'b0, 20000, ok);
        chk("f1_start_seen", 32'(ok), 32'd1);
        wait_cyc(20);
        chk("f1_vcnt", 32'(a_vcnt - v0), 32'd1);
        chk("f1_digits", a_dig, 32'h4500_2307);
        chk("f1_flags", {a_busy, a_err}, 32'b00);

        // bad checksum
        v0 = a_vcnt;
        pulse_start();
        sensor_frame(0, 40'h2D_00_17_07_4C, -1, 1'b0, 20000, ok);
        wait_cyc(20);
        chk("cs_vcnt", 32'(a_vcnt - v0), 32'd0);
        chk("cs_err", {a_busy, a_err}, 32'b01);
        chk("cs_hold", a_dig, 32'h4500_2307);

        // good frame with 28/39/40/70 us widths; extra start mid-frame is ignored
        v0 = a_vcnt;
        pulse_start();
        fork
            sensor_frame(0, 40'h38_09_1A_05_60, -1, 1'b1, 20000, ok);
            begin wait_us(500); pulse_start(); end
        join
        wait_cyc(20);
        chk("wid_digits", a_dig, 32'h5609_2605);
        chk("wid_err_clr", {a_busy, a_err}, 32'b00);
        wait_us(300);
        chk("busy_start_vcnt", 32'(a_vcnt - v0), 32'd1);
        chk("busy_start_idle", {a_busy, dht_a}, 32'b01);

        // no sensor response
        v0 = a_vcnt;
        pulse_start();
        wait_us(250);
        chk("to_early", {a_busy, a_err}, 32'b10);
        wait_us(100);
        chk("to_err", {a_busy, a_err, dht_a}, 32'b011);
        chk("to_hold", a_dig, 32'h5609_2605);
        chk("to_vcnt", 32'(a_vcnt - v0), 32'd0);

        // reset mid-frame at bit 20
        v0 = a_vcnt;
        pulse_start();
        sensor_frame(0, 40'h2D_00_17_07_4B, 20, 1'b0, 20000, ok);
        #(10 * US);
        chk("mid_busy", 32'(a_busy), 32'd1);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_digits", a_dig, 32'h0);
        chk("mid_rst_flags", {a_busy, a_valid, a_err, dht_a}, 32'b0001);
        wait_cyc(3);
        @(negedge clk) rst_a = 1'b1;
        wait_us(100);
        chk("mid_novalid", 32'(a_vcnt - v0), 32'd0);

        // reset while driving the start pulse releases the line at once
        pulse_start();
        wait_us(50);
        chk("sl_drive", 32'(dht_a), 32'd0);
        rst_a = 1'b0;
        #1;
        chk("sl_release", 32'(dht_a), 32'd1);
        wait_cyc(3);
        @(negedge clk) rst_a = 1'b1;
        wait_cyc(5);

        // fresh frame after reset
        v0 = a_vcnt;
        pulse_start();
        sensor_frame(0, 40'h2D_00_17_07_4B, -1, 1'b0, 20000, ok);
        chk("fr_start_seen", 32'(ok), 32'd1);
        wait_cyc(20);
        chk("fr_vcnt", 32'(a_vcnt - v0), 32'd1);
        chk("fr_digits", a_dig, 32'h4500_2307);
        chk("fr_flags", {a_busy, a_err}, 32'b00);

        for (int k = 0; k < 30000 && !poll_done; k++) @(posedge clk);
        chk("poll_done", 32'(poll_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
